shift_register_piso: RTL and testbench
======================================

SHIFT_REGISTER_PISO -- requirements
Module: shift_register_piso

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits; legal range 2..32.
REQ-002 Parameter LSB_FIRST, default 0: 0 sends MSB first, 1 sends LSB first.
REQ-003 i_CLOCK_POS  input  1  sole clock; all state updates occur on its rising edge.
REQ-004 i_RESET_NEG  input  1  asynchronous, active-low reset.
REQ-005 i_LOAD_DATA  input  WIDTH  parallel word to transmit.
REQ-006 i_LOAD_VALID  input  1  i_LOAD_DATA is valid this cycle.
REQ-007 o_LOAD_READY  output  1  block accepts a word this cycle.
REQ-008 i_SHIFT_EN  input  1  bit-advance enable; when low, the current bit is held.
REQ-009 o_SIGNAL_OUT  output  1  serial data bit, registered.
REQ-010 o_SIGNAL_VALID  output  1  o_SIGNAL_OUT carries a frame bit, registered.
REQ-011 o_LAST_BIT  output  1  current bit is the final bit of the frame, registered.

Function
REQ-012 The block SHALL implement the states IDLE and SHIFT, plus PARITY when the REQ-025 macro is defined.
REQ-013 A load SHALL occur on any rising edge where i_LOAD_VALID=1 and o_LOAD_READY=1; the word is captured into the shift register and the bit counter is cleared to 0.
REQ-014 o_LOAD_READY SHALL equal (state==IDLE) OR (o_LAST_BIT=1 AND i_SHIFT_EN=1); it is combinational and has no dependency on i_LOAD_VALID.
REQ-015 The first data bit SHALL appear on o_SIGNAL_OUT, with o_SIGNAL_VALID=1, in the cycle immediately after the load edge, giving one cycle of latency.
REQ-016 On each edge in SHIFT with i_SHIFT_EN=1 and the counter below WIDTH-1, the block SHALL present the next bit and increment the counter.
REQ-017 When i_SHIFT_EN=0, o_SIGNAL_OUT, o_SIGNAL_VALID, o_LAST_BIT and the counter SHALL hold.
REQ-018 o_LAST_BIT SHALL be 1 while the final frame bit is presented: data bit WIDTH-1 without parity, or the parity bit with parity.
REQ-019 On the final-bit edge with i_SHIFT_EN=1, a simultaneous valid load SHALL start the next frame with no gap; otherwise the block SHALL enter IDLE with o_SIGNAL_VALID=0 and o_SIGNAL_OUT=0.
REQ-020 In IDLE, o_SIGNAL_OUT SHALL be 0, and i_SHIFT_EN SHALL have no effect.
REQ-021 While in SHIFT and not on the final bit, i_LOAD_VALID SHALL be ignored; the source must hold its word until o_LOAD_READY=1.

Reset
REQ-022 Assertion of i_RESET_NEG=0 SHALL immediately and asynchronously force state=IDLE, counter=0, shift register=0, o_SIGNAL_OUT=0, o_SIGNAL_VALID=0 and o_LAST_BIT=0.
REQ-023 A reset asserted mid-frame SHALL abort the frame, with no partial bits emitted after release.
REQ-024 o_LOAD_READY SHALL read 1 during reset, and the first load SHALL be accepted on the first rising edge after release.

Configuration
REQ-025 With macro SHIFT_REGISTER_PISO_PARITY_EN defined, each frame SHALL be WIDTH data bits followed by one even-parity bit (XOR of the loaded word), presented in state PARITY.
REQ-026 With SHIFT_REGISTER_PISO_PARITY_EN undefined, the frame SHALL be exactly WIDTH bits, and no parity logic or PARITY state SHALL be present.

Structure
REQ-027 State encodings (IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2) and the WIDTH legal limits SHALL live in the shared package/header shift_register_pkg.
REQ-028 The bit counter SHALL be a separate sub-module, bit_counter: a modulo counter with clear, enable and terminal-count output, sized $clog2(WIDTH+1).

Verification
REQ-029 WIDTH=8, LSB_FIRST=0, no parity, load 8'hA5 with i_SHIFT_EN=1 -> o_SIGNAL_OUT 1,0,1,0,0,1,0,1 on the 8 cycles after the load; o_LAST_BIT only on the 8th; then IDLE.
REQ-030 LSB_FIRST=1, load 8'h01 -> bits 1,0,0,0,0,0,0,0.
REQ-031 Back-to-back: load 8'hFF, with 8'h00 valid on the final-bit edge -> 16 contiguous valid bits, o_SIGNAL_VALID never drops.
REQ-032 Toggle i_SHIFT_EN 1,0,0,1 mid-frame on 8'hC3 -> each bit held for the stalled cycles; sequence intact; o_LOAD_READY=0 throughout the stall.
REQ-033 Pulse i_RESET_NEG low between clock edges during bit 4 -> outputs 0 within the same cycle; after release, load 8'h5A -> clean frame.
REQ-034 Parity macro defined, load 8'h07 -> 8 data bits, then parity bit 1 with o_LAST_BIT=1; for 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/shift_register_pkg.sv
// Shared state encodings and width limits for the PISO shifter.
// The PARITY state only exists when SHIFT_REGISTER_PISO_PARITY_EN is defined.
package shift_register_pkg;

  localparam int unsigned WidthMin = 2;
  localparam int unsigned WidthMax = 32;

`ifdef SHIFT_REGISTER_PISO_PARITY_EN
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StParity = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1
  } state_e;
`endif

endpackage

// File: rtl/bit_counter.sv
// Modulo counter with synchronous clear, enable and terminal-count flag.
module bit_counter #(
  parameter int unsigned Modulus = 8,
  parameter int unsigned CntW    = $clog2(Modulus + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [CntW-1:0] cnt_o,
  output logic            tc_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  assign tc_o  = (cnt_q == CntW'(Modulus - 1));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_register_piso.sv
// Parallel-in serial-out shifter with ready/valid load and registered serial outputs.
// Define SHIFT_REGISTER_PISO_PARITY_EN to append an even-parity bit to every frame.
module shift_register_piso
  import shift_register_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic             i_CLOCK_POS,
  input  logic             i_RESET_NEG,
  input  logic [WIDTH-1:0] i_LOAD_DATA,
  input  logic             i_LOAD_VALID,
  output logic             o_LOAD_READY,
  input  logic             i_SHIFT_EN,
  output logic             o_SIGNAL_OUT,
  output logic             o_SIGNAL_VALID,
  output logic             o_LAST_BIT
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

`ifdef SHIFT_REGISTER_PISO_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  if (WIDTH < WidthMin || WIDTH > WidthMax) begin : gen_width_check
    $error("shift_register_piso: WIDTH out of range");
  end

  state_e           state_d, state_q;
  logic [WIDTH-1:0] shreg_d, shreg_q;
  logic             out_d, out_q;
  logic             valid_d, valid_q;
  logic             last_d, last_q;
  logic             load_ready, do_load, frame_end;
  logic             cnt_clr, cnt_en, cnt_tc;
  logic [CntW-1:0]  cnt;

`ifdef SHIFT_REGISTER_PISO_PARITY_EN
  logic parity_d, parity_q;
`endif

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  // The register always holds the not-yet-presented bits aligned at the head.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  bit_counter #(
    .Modulus(WIDTH)
  ) u_bit_counter (
    .clk_i (i_CLOCK_POS),
    .rst_ni(i_RESET_NEG),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt),
    .tc_o  (cnt_tc)
  );

  assign load_ready   = (state_q == StIdle) || (last_q && i_SHIFT_EN);
  assign do_load      = i_LOAD_VALID && load_ready;
  assign o_LOAD_READY = load_ready;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    out_d     = out_q;
    valid_d   = valid_q;
    last_d    = last_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    frame_end = 1'b0;
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      StIdle: ;
      StShift: begin
        if (i_SHIFT_EN) begin
          if (!cnt_tc) begin
            cnt_en  = 1'b1;
            out_d   = head_bit(shreg_q);
            shreg_d = advance(shreg_q);
            last_d  = !ParityEn && (cnt == CntW'(WIDTH - 2));
          end else begin
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
            state_d = StParity;
            out_d   = parity_q;
            last_d  = 1'b1;
`else
            frame_end = 1'b1;
`endif
          end
        end
      end
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
      StParity: begin
        if (i_SHIFT_EN) begin
          frame_end = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (frame_end) begin
      state_d = StIdle;
      out_d   = 1'b0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      cnt_clr = 1'b1;
    end

    // A load overrides frame end so back-to-back frames have no gap.
    if (do_load) begin
      state_d = StShift;
      cnt_clr = 1'b1;
      out_d   = head_bit(i_LOAD_DATA);
      shreg_d = advance(i_LOAD_DATA);
      valid_d = 1'b1;
      last_d  = 1'b0;
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
      parity_d = ^i_LOAD_DATA;
`endif
    end
  end

  always_ff @(posedge i_CLOCK_POS or negedge i_RESET_NEG) begin
    if (!i_RESET_NEG) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      out_q    <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign o_SIGNAL_OUT   = out_q;
  assign o_SIGNAL_VALID = valid_q;
  assign o_LAST_BIT     = last_q;

endmodule

// File: tb/tb_shift_register_piso.sv
// Bench for shift_register_piso: MSB-first and LSB-first instances share stimulus,
// expected serial bits are queued at drive time and checked as the DUTs present them.
module tb_shift_register_piso;

`ifdef SHIFT_REGISTER_PISO_PARITY_EN
  localparam bit ParityEn = 1'b1;
  localparam int FrameLen = 9;
`else
  localparam bit ParityEn = 1'b0;
  localparam int FrameLen = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ld_data = 8'h00;
  logic       ld_valid = 1'b0;
  logic       sh_en = 1'b0;
  logic       ready_m, out_m, valid_m, last_m;
  logic       ready_l, out_l, valid_l, last_l;

  always #5 clk = ~clk;

  shift_register_piso #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
    .i_CLOCK_POS   (clk),
    .i_RESET_NEG   (rst_n),
    .i_LOAD_DATA   (ld_data),
    .i_LOAD_VALID  (ld_valid),
    .o_LOAD_READY  (ready_m),
    .i_SHIFT_EN    (sh_en),
    .o_SIGNAL_OUT  (out_m),
    .o_SIGNAL_VALID(valid_m),
    .o_LAST_BIT    (last_m)
  );

  shift_register_piso #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_l (
    .i_CLOCK_POS   (clk),
    .i_RESET_NEG   (rst_n),
    .i_LOAD_DATA   (ld_data),
    .i_LOAD_VALID  (ld_valid),
    .o_LOAD_READY  (ready_l),
    .i_SHIFT_EN    (sh_en),
    .o_SIGNAL_OUT  (out_l),
    .o_SIGNAL_VALID(valid_l),
    .o_LAST_BIT    (last_l)
  );

  typedef struct packed {
    logic m;
    logic l;
    logic lst;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] seq_m;  // serial order, first bit at [7]
    logic [7:0] seq_l;
    logic       par;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   tests = 0;
  int   fails = 0;
  int   cycles = 0;
  bit   acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] sm, input logic [7:0] sl, input logic par);
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{m: sm[7-i], l: sl[7-i], lst: (i == 7) && !ParityEn});
    end
    if (ParityEn) sb.push_back('{m: par, l: par, lst: 1'b1});
  endtask

  // A presented bit is consumed on any edge where it is valid and shifting is enabled.
  always @(posedge clk) begin
    if (rst_n && valid_m && sh_en && sb.size() > 0) void'(sb.pop_front());
  end

  task automatic check_outputs();
    if (valid_m) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        chk("out_m", out_m, sb[0].m);
        chk("out_l", out_l, sb[0].l);
        chk("last_m", last_m, sb[0].lst);
        chk("last_l", last_l, sb[0].lst);
        chk("valid_l", valid_l, 1'b1);
      end
    end else begin
      chk("idle_outs", {out_m, last_m, out_l, last_l, valid_l}, 32'd0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cycles++;
    if (cycles > 20000) begin
      $display("FAIL timeout: got %0d cycles expected under 20000", cycles);
      $fatal(1);
    end
    check_outputs();
  endtask

  task automatic step();
    #1;
    acc = ld_valid && ready_m;
    tick();
    if (acc) ld_valid = 1'b0;
  endtask

  task automatic run_frame(input int idx);
    ld_data  = vecs[idx].data;
    ld_valid = 1'b1;
    sh_en    = 1'b1;
    push_frame(vecs[idx].seq_m, vecs[idx].seq_l, vecs[idx].par);
    step();
    chk("first_bit_valid", valid_m, 1'b1);
    repeat (FrameLen - 1) step();
    step();
    chk("frame_end_idle", valid_m, 1'b0);
    chk("idle_ready", ready_m, 1'b1);
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, seq_m: 8'hA5, seq_l: 8'hA5, par: 1'b0};
    vecs[1] = '{data: 8'h01, seq_m: 8'h01, seq_l: 8'h80, par: 1'b1};
    vecs[2] = '{data: 8'h0F, seq_m: 8'h0F, seq_l: 8'hF0, par: 1'b0};
    vecs[3] = '{data: 8'h80, seq_m: 8'h80, seq_l: 8'h01, par: 1'b1};
    vecs[4] = '{data: 8'h07, seq_m: 8'h07, seq_l: 8'hE0, par: 1'b1};
    vecs[5] = '{data: 8'h03, seq_m: 8'h03, seq_l: 8'hC0, par: 1'b0};
    vecs[6] = '{data: 8'h5A, seq_m: 8'h5A, seq_l: 8'h5A, par: 1'b0};

    // Reset state, and ready while in reset.
    #2;
    chk("rst_valid", valid_m, 1'b0);
    chk("rst_out", out_m, 1'b0);
    chk("rst_last", last_m, 1'b0);
    chk("rst_ready", ready_m, 1'b1);

    // First load accepted on the first edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0);

    for (int i = 1; i < 6; i++) run_frame(i);

    // Back-to-back: 00 held valid from the first bit of FF until accepted.
    ld_data  = 8'hFF;
    ld_valid = 1'b1;
    sh_en    = 1'b1;
    push_frame(8'hFF, 8'hFF, 1'b0);
    step();
    chk("b2b_valid", valid_m, 1'b1);
    ld_data  = 8'h00;
    ld_valid = 1'b1;
    push_frame(8'h00, 8'h00, 1'b0);
    #1;
    chk("b2b_ready_mid", ready_m, 1'b0);
    for (int j = 1; j < 2 * FrameLen; j++) begin
      step();
      chk("b2b_valid", valid_m, 1'b1);
    end
    step();
    chk("b2b_end_idle", valid_m, 1'b0);

    // Stall pattern 1,0,0,1 while bit1 of C3 is presented.
    ld_data  = 8'hC3;
    ld_valid = 1'b1;
    sh_en    = 1'b1;
    push_frame(8'hC3, 8'hC3, 1'b0);
    step();
    step();
    sh_en = 1'b0;
    step();
    chk("stall_ready", ready_m, 1'b0);
    step();
    chk("stall_ready", ready_m, 1'b0);
    sh_en = 1'b1;
    repeat (FrameLen - 2) step();
    step();
    chk("stall_end_idle", valid_m, 1'b0);

    // Asynchronous reset during bit 4, released before the next edge.
    ld_data  = 8'hA5;
    ld_valid = 1'b1;
    sh_en    = 1'b1;
    push_frame(8'hA5, 8'hA5, 1'b0);
    repeat (5) step();
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_outs", {valid_m, out_m, last_m, valid_l, out_l, last_l}, 32'd0);
    chk("arst_ready", ready_m, 1'b1);
    sb.delete();
    #1;
    rst_n = 1'b1;
    tick();
    chk("arst_no_partial", valid_m, 1'b0);
    tick();
    chk("arst_no_partial", valid_m, 1'b0);
    run_frame(6);

    chk("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
